ddfs_mc: RTL and testbench
==========================

DDFS_MC -- requirements
Module: ddfs_mc

Interface
REQ-001 Parameter PHASE_WIDTH, default 30, phase accumulator width in bits.
REQ-002 Parameter NUM_CH, default 4, number of channels (power of two, 2..16).
REQ-003 Parameter CH_W, default $clog2(NUM_CH), channel index width.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cfg_we  in  1  configuration write strobe.
REQ-007 cfg_ch  in  CH_W  target channel for the write.
REQ-008 cfg_addr  in  2  target register: 0 fcw, 1 pha (phase offset), 2 env (Q2.14 signed, low 16 bits), 3 mode (low 2 bits).
REQ-009 cfg_wdata  in  PHASE_WIDTH  write data, LSB-aligned.
REQ-010 tick_i  in  1  sample-rate strobe that starts one frame.
REQ-011 busy_o  out  1  frame in progress.
REQ-012 mix_o  out  16+CH_W  signed sum of all channel samples, held between frames.
REQ-013 mix_valid_o  out  1  one-cycle pulse when mix_o updates.
REQ-014 pulse_o  out  NUM_CH  MSB of each channel's phase register.
REQ-015 overrun_o  out  1  sticky flag: a tick was dropped.

Function
REQ-016 Config registers SHALL update on the rising edge where cfg_we=1; a write SHALL take effect from the next accepted tick.
REQ-017 tick_i with busy_o=0 SHALL be accepted: all config registers are copied to a frame shadow using pre-write values when cfg_we coincides, and busy_o rises the next cycle.
REQ-018 tick_i with busy_o=1 SHALL be dropped and SHALL set overrun_o; overrun_o SHALL clear only on a cfg_we with cfg_addr=3.
REQ-019 Sequencer states: IDLE -> ISSUE (NUM_CH cycles, channel 0 upward) -> DRAIN (3 cycles) -> IDLE.
REQ-020 In its ISSUE slot, channel k SHALL form pha_mod = phase[k] + pha[k] (mod 2^PHASE_WIDTH) from the pre-increment phase, then update phase[k] <= phase[k] + fcw[k] with wrap.
REQ-021 The sample SHALL be selected by mode: 0 sine = wave_rom at pha_mod[PW-1:PW-8]; 1 square = +32767 if pha_mod MSB is 0, else -32767; 2 saw = pha_mod[PW-1:PW-16] with its MSB inverted, read as signed; 3 off = 0.
REQ-022 Pipeline: slot -> ROM/selection register -> product register, where product = signed sample * signed env and the scaled value is product[29:14] -> accumulate.
REQ-023 The accumulator SHALL clear at frame start and sign-extend each scaled value to 16+CH_W bits; there SHALL be no saturation, and the width is sufficient for overflow-free summation.
REQ-024 mix_o and mix_valid_o SHALL update exactly NUM_CH+4 cycles after the edge that accepted the tick; busy_o SHALL fall in that same cycle, so the next tick can be accepted on that edge.
REQ-025 pulse_o[k] SHALL reflect phase[k] MSB continuously and SHALL change only in channel k's slot.
REQ-026 fcw=0 SHALL freeze the phase; fcw=2^(PW-1) SHALL toggle pulse_o[k] every frame.

Reset
REQ-027 On reset_n=0, all phases, config, shadow, accumulator, mix_o, mix_valid_o, busy_o and overrun_o SHALL be 0, and the FSM SHALL enter IDLE immediately.
REQ-028 Reset mid-frame SHALL abort the frame without producing a mix_valid_o pulse; the first tick after release SHALL start a clean frame.

Structure
REQ-029 Package ddfs_pkg SHALL hold the mode enum (SINE, SQUARE, SAW, OFF), the cfg_addr enum, the FSM state enum, and the constants SQ_AMP=32767 and ENV_Q=14.
REQ-030 The design SHALL instantiate a single shared wave_rom (256x16 signed, 1-cycle synchronous read), time-multiplexed across all channels; no other sub-module is required.

Verification
REQ-031 Reset, then a tick with all config at 0 -> mix_o=0, mix_valid_o pulses at cycle NUM_CH+4, and overrun_o=0.
REQ-032 ch0 mode=1, env=0x4000, others off; tick -> mix_o=+32767; set pha=2^(PW-1) and tick -> mix_o=-32767.
REQ-033 ch0 fcw=2^(PW-1), mode=3; ticks 1..4 -> pulse_o[0] reads 1,0,1,0 after each frame.
REQ-034 All 4 channels square at +32767 with env=0x4000 -> mix_o=131068 with no wrap.
REQ-035 A tick while busy -> no extra mix_valid_o and overrun_o=1; cfg write to addr 3 -> overrun_o=0.
REQ-036 Assert reset_n=0 in ISSUE slot 2 -> outputs are 0 the same cycle, no mix_valid_o; after release, a tick gives the correct frame.

Source files
------------

// File: rtl/ddfs_pkg.sv
// Shared types and constants for the multi-channel DDFS: register map, waveform modes,
// sequencer states and fixed-point scaling.
package ddfs_pkg;
  typedef enum logic [1:0] {SINE, SQUARE, SAW, OFF} mode_e;
  typedef enum logic [1:0] {A_FCW, A_PHA, A_ENV, A_MODE} cfg_addr_e;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  localparam int SQ_AMP    = 32767;
  localparam int ENV_Q     = 14;
  localparam int SMP_W     = 16;
  localparam int DRAIN_CYC = 3;
endpackage

// File: rtl/ddfs_mc_rom.sv
// Shared 256x16 signed sine table with a 1-cycle registered read.
// Table uses a Bhaskara rational approximation so it elaborates from integer math alone.
module wave_rom
  import ddfs_pkg::*;
(
  input  logic               clk,
  input  logic [7:0]         addr,
  output logic signed [15:0] data
);
  // sin(pi*p/128) ~= 16q / (81920 - 4q), q = p*(128-p); pi cancels out
  function automatic logic signed [15:0] sin_val(input int i);
    int p;
    int q;
    longint v;
    logic signed [15:0] r;
    p = i % 128;
    q = p * (128 - p);
    v = (longint'(SQ_AMP) * longint'(16 * q)) / longint'(81920 - 4 * q);
    r = 16'(v);
    return (i >= 128) ? -r : r;
  endfunction

  logic signed [15:0] lut [256];

  for (genvar i = 0; i < 256; i++) begin : g_lut
    assign lut[i] = sin_val(i);
  end

  always_ff @(posedge clk) data <= lut[addr];
endmodule

// File: rtl/ddfs_mc.sv
// Multi-channel DDFS: per-channel phase accumulators time-multiplexed over one sine ROM,
// envelope-scaled and summed into one mix sample per tick.
module ddfs_mc
  import ddfs_pkg::*;
#(
  parameter int PHASE_WIDTH = 30,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cfg_we,
  input  logic [CH_W-1:0]            cfg_ch,
  input  logic [1:0]                 cfg_addr,
  input  logic [PHASE_WIDTH-1:0]     cfg_wdata,
  input  logic                       tick_i,
  output logic                       busy_o,
  output logic signed [16+CH_W-1:0]  mix_o,
  output logic                       mix_valid_o,
  output logic [NUM_CH-1:0]          pulse_o,
  output logic                       overrun_o
);
  localparam int PW     = PHASE_WIDTH;
  localparam int MW     = SMP_W + CH_W;
  localparam int STAGES = 2;
  localparam logic signed [15:0] SQ_P = 16'(SQ_AMP);
  localparam logic signed [15:0] SQ_N = 16'(-SQ_AMP);

  logic [NUM_CH-1:0][PW-1:0] fcw, pha, sh_fcw, sh_pha, phase;
  logic [NUM_CH-1:0][15:0]   env, sh_env;
  logic [NUM_CH-1:0][1:0]    mode, sh_mode;

  state_e          state;
  logic [CH_W-1:0] slot;
  logic [1:0]      dcnt;
  logic            done;
  logic            accept;

  logic [STAGES:0]     vld_pipe;
  logic [PW-1:0]       pha_mod;
  logic [15:0]         s1_top, s2_top;
  logic [1:0]          s1_mode, s2_mode;
  logic signed [15:0]  s1_env, s2_env;
  logic signed [15:0]  rom_q, sample, s3_scaled;
  logic signed [31:0]  prod;
  logic signed [MW-1:0] acc;
  logic                unused_prod;

  assign accept  = tick_i & ~busy_o;
  assign pha_mod = phase[slot] + sh_pha[slot];

  always_comb begin
    pulse_o = '0;
    for (int k = 0; k < NUM_CH; k++) pulse_o[k] = phase[k][PW-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcw       <= '0;
      pha       <= '0;
      env       <= '0;
      mode      <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr_e'(cfg_addr))
          A_FCW:  fcw[cfg_ch]  <= cfg_wdata;
          A_PHA:  pha[cfg_ch]  <= cfg_wdata;
          A_ENV:  env[cfg_ch]  <= cfg_wdata[15:0];
          A_MODE: mode[cfg_ch] <= cfg_wdata[1:0];
          default: ;
        endcase
      end
      // Clearing write wins over a simultaneous dropped tick
      if (cfg_we && cfg_addr == A_MODE) overrun_o <= 1'b0;
      else if (tick_i && busy_o)        overrun_o <= 1'b1;
    end
  end

  // Sequencer; busy_o stays high one cycle past DRAIN so it drops with mix_valid_o
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      slot        <= '0;
      dcnt        <= '0;
      done        <= 1'b0;
      busy_o      <= 1'b0;
      sh_fcw      <= '0;
      sh_pha      <= '0;
      sh_env      <= '0;
      sh_mode     <= '0;
      phase       <= '0;
      mix_o       <= '0;
      mix_valid_o <= 1'b0;
    end else begin
      done        <= 1'b0;
      mix_valid_o <= 1'b0;
      if (done) begin
        mix_o       <= acc;
        mix_valid_o <= 1'b1;
        busy_o      <= 1'b0;
      end
      case (state)
        IDLE: if (accept) begin
          sh_fcw  <= fcw;
          sh_pha  <= pha;
          sh_env  <= env;
          sh_mode <= mode;
          slot    <= '0;
          busy_o  <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: begin
          phase[slot] <= phase[slot] + sh_fcw[slot];
          slot        <= slot + CH_W'(1);
          if (slot == CH_W'(NUM_CH - 1)) begin
            dcnt  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dcnt == 2'(DRAIN_CYC - 1)) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            dcnt <= dcnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  wave_rom u_rom (
    .clk  (clk),
    .addr (s1_top[15:8]),
    .data (rom_q)
  );

  always_comb begin
    sample = '0;
    case (mode_e'(s2_mode))
      SINE:    sample = rom_q;
      SQUARE:  sample = s2_top[15] ? SQ_N : SQ_P;
      SAW:     sample = signed'({~s2_top[15], s2_top[14:0]});
      default: sample = '0;
    endcase
  end

  assign prod        = 32'(sample) * 32'(s2_env);
  assign unused_prod = ^{prod[31:ENV_Q+16], prod[ENV_Q-1:0]};

  // slot -> ROM/selection -> product -> accumulate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      s1_top    <= '0;
      s1_mode   <= '0;
      s1_env    <= '0;
      s2_top    <= '0;
      s2_mode   <= '0;
      s2_env    <= '0;
      s3_scaled <= '0;
      acc       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], state == ISSUE};
      if (state == ISSUE) begin
        s1_top  <= pha_mod[PW-1:PW-16];
        s1_mode <= sh_mode[slot];
        s1_env  <= signed'(sh_env[slot]);
      end
      s2_top    <= s1_top;
      s2_mode   <= s1_mode;
      s2_env    <= s1_env;
      s3_scaled <= prod[ENV_Q+15:ENV_Q];
      if (accept)           acc <= '0;
      else if (vld_pipe[2]) acc <= acc + MW'(s3_scaled);
    end
  end
endmodule

// File: tb/tb_ddfs_mc.sv
// Directed bench for ddfs_mc: frame latency, waveform modes, envelope scaling,
// multi-channel sum, overrun handling and mid-frame reset.
module tb_ddfs_mc;
  localparam int NUM_CH = 4;
  localparam int LAT    = NUM_CH + 4;
  localparam logic [29:0] HALF = 30'h2000_0000;
  localparam logic [29:0] QTR  = 30'h1000_0000;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               cfg_we;
  logic [1:0]         cfg_ch;
  logic [1:0]         cfg_addr;
  logic [29:0]        cfg_wdata;
  logic               tick_i;
  logic               busy_o;
  logic signed [17:0] mix_o;
  logic               mix_valid_o;
  logic [3:0]         pulse_o;
  logic               overrun_o;

  int checks = 0;
  int errors = 0;

  ddfs_mc #(.PHASE_WIDTH(30), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .tick_i(tick_i),
    .busy_o(busy_o), .mix_o(mix_o), .mix_valid_o(mix_valid_o),
    .pulse_o(pulse_o), .overrun_o(overrun_o)
  );

  initial forever #5 clk = ~clk;

  task automatic do_cfg(input int ch, input int addr, input logic [29:0] d);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_addr = 2'(addr); cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Ticks once and returns edges from the accepting edge to mix_valid_o (capped)
  task automatic run_frame(output int lat);
    tick_i = 1'b1;
    @(posedge clk); #1;
    tick_i = 1'b0;
    lat = 0;
    while (!mix_valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy_o, mix_valid_o, overrun_o, pulse_o} !== 7'b0 || mix_o !== 18'sd0) begin
      errors++;
      $display("FAIL reset_state busy=%0b valid=%0b ovr=%0b pulse=%b mix=%0d want all 0",
               busy_o, mix_valid_o, overrun_o, pulse_o, mix_o);
    end
  endtask

  task automatic test_zero_frame;
    int lat;
    run_frame(lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, LAT); end
    checks++;
    if (mix_o !== 18'sd0) begin errors++; $display("FAIL zero_mix got %0d want 0", mix_o); end
    @(posedge clk); #1;
    checks++;
    if (overrun_o !== 1'b0 || busy_o !== 1'b0 || mix_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_after ovr=%0b busy=%0b valid=%0b want 0 0 0", overrun_o, busy_o, mix_valid_o);
    end
  endtask

  task automatic test_square;
    int lat;
    do_cfg(0, 3, 30'd1);
    do_cfg(0, 2, 30'h4000);
    run_frame(lat);
    checks++;
    if (lat !== LAT || mix_o !== 18'sd32767) begin
      errors++; $display("FAIL square_pos lat=%0d mix=%0d want %0d 32767", lat, mix_o, LAT);
    end
    do_cfg(0, 1, HALF);
    run_frame(lat);
    checks++;
    if (mix_o !== -18'sd32767) begin errors++; $display("FAIL square_neg got %0d want -32767", mix_o); end
    // write coinciding with the accepting tick must not reach this frame
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 2'd1; cfg_wdata = 30'd0; tick_i = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; tick_i = 1'b0;
    lat = 0;
    while (!mix_valid_o && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== LAT || mix_o !== -18'sd32767) begin
      errors++; $display("FAIL coincident_write lat=%0d mix=%0d want %0d -32767", lat, mix_o, LAT);
    end
    run_frame(lat);
    checks++;
    if (mix_o !== 18'sd32767) begin errors++; $display("FAIL write_next_tick got %0d want 32767", mix_o); end
  endtask

  task automatic test_env_scale;
    int lat;
    do_cfg(0, 2, 30'h0000_C000);
    run_frame(lat);
    checks++;
    if (mix_o !== -18'sd32767) begin errors++; $display("FAIL env_neg got %0d want -32767", mix_o); end
    do_cfg(0, 2, 30'h2000);
    run_frame(lat);
    checks++;
    if (mix_o !== 18'sd16383) begin errors++; $display("FAIL env_half got %0d want 16383", mix_o); end
    do_cfg(0, 2, 30'h4000);
  endtask

  task automatic test_saw;
    int lat;
    do_cfg(0, 3, 30'd2);
    run_frame(lat);
    checks++;
    if (mix_o !== -18'sd32768) begin errors++; $display("FAIL saw_zero got %0d want -32768", mix_o); end
    do_cfg(0, 1, HALF);
    run_frame(lat);
    checks++;
    if (mix_o !== 18'sd0) begin errors++; $display("FAIL saw_mid got %0d want 0", mix_o); end
    do_cfg(0, 1, 30'h3FFF_C000);
    run_frame(lat);
    checks++;
    if (mix_o !== 18'sd32767) begin errors++; $display("FAIL saw_top got %0d want 32767", mix_o); end
  endtask

  task automatic test_sine;
    int lat;
    do_cfg(0, 3, 30'd0);
    do_cfg(0, 1, QTR);
    run_frame(lat);
    checks++;
    if (mix_o !== 18'sd32767) begin errors++; $display("FAIL sine_peak got %0d want 32767", mix_o); end
    do_cfg(0, 1, HALF | QTR);
    run_frame(lat);
    checks++;
    if (mix_o !== -18'sd32767) begin errors++; $display("FAIL sine_trough got %0d want -32767", mix_o); end
    do_cfg(0, 1, 30'd0);
    run_frame(lat);
    checks++;
    if (mix_o !== 18'sd0) begin errors++; $display("FAIL sine_zero got %0d want 0", mix_o); end
  endtask

  task automatic test_pulse;
    int lat;
    logic [3:0] exp_pulse [4];
    exp_pulse[0] = 4'b0001; exp_pulse[1] = 4'b0000;
    exp_pulse[2] = 4'b0001; exp_pulse[3] = 4'b0000;
    do_cfg(0, 3, 30'd3);
    do_cfg(0, 0, HALF);
    for (int t = 0; t < 4; t++) begin
      run_frame(lat);
      checks++;
      if (pulse_o !== exp_pulse[t] || mix_o !== 18'sd0) begin
        errors++;
        $display("FAIL pulse_tick%0d pulse=%b mix=%0d want %b 0", t + 1, pulse_o, mix_o, exp_pulse[t]);
      end
    end
  endtask

  task automatic test_all_square;
    int lat;
    do_cfg(0, 0, 30'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      do_cfg(c, 3, 30'd1);
      do_cfg(c, 2, 30'h4000);
    end
    run_frame(lat);
    checks++;
    if (lat !== LAT || mix_o !== 18'sd131068) begin
      errors++; $display("FAIL all_square_pos lat=%0d mix=%0d want %0d 131068", lat, mix_o, LAT);
    end
    for (int c = 0; c < NUM_CH; c++) do_cfg(c, 1, HALF);
    run_frame(lat);
    checks++;
    if (mix_o !== -18'sd131068) begin errors++; $display("FAIL all_square_neg got %0d want -131068", mix_o); end
  endtask

  task automatic test_overrun;
    int pulses;
    tick_i = 1'b1;
    @(posedge clk); #1;
    tick_i = 1'b0;
    @(posedge clk); #1;
    tick_i = 1'b1;
    @(posedge clk); #1;
    tick_i = 1'b0;
    pulses = 0;
    repeat (25) begin
      if (mix_valid_o) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL overrun_pulses got %0d want 1", pulses); end
    checks++;
    if (overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_set got %0b want 1", overrun_o); end
    do_cfg(0, 3, 30'd1);
    checks++;
    if (overrun_o !== 1'b0) begin errors++; $display("FAIL overrun_clear got %0b want 0", overrun_o); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    int lat;
    tick_i = 1'b1;
    @(posedge clk); #1;
    tick_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, mix_valid_o, overrun_o, pulse_o} !== 7'b0 || mix_o !== 18'sd0) begin
      errors++;
      $display("FAIL midreset_outputs busy=%0b valid=%0b ovr=%0b pulse=%b mix=%0d want all 0",
               busy_o, mix_valid_o, overrun_o, pulse_o, mix_o);
    end
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (mix_valid_o) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midreset_no_pulse got %0d want 0", pulses); end
    do_cfg(0, 3, 30'd1);
    do_cfg(0, 2, 30'h4000);
    run_frame(lat);
    checks++;
    if (lat !== LAT || mix_o !== 18'sd32767) begin
      errors++; $display("FAIL midreset_recover lat=%0d mix=%0d want %0d 32767", lat, mix_o, LAT);
    end
  endtask

  initial begin
    reset_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0; tick_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    test_reset;
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_zero_frame;
    test_square;
    test_env_scale;
    test_saw;
    test_sine;
    test_pulse;
    test_all_square;
    test_overrun;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
